apb_slave_decoder_32bit: RTL and testbench

- Sits directly downstream of the UART-to-APB control master and consumes its p_ce/p_addr/p_wdata/p_enable/p_we request bus.
- Decodes the top address bits to one of NUM_SLV register slaves, sequences a two-phase access to that slave, and returns a single-cycle p_rdy with read data.
- Guards the master against hung or unmapped slaves with an error response and a sticky error flag.

---
 rtl/apb_dec_pkg.sv | 15 +
 rtl/apb_slave_decoder_32bit_timeout_cnt.sv | 26 ++
 rtl/apb_slave_decoder_32bit.sv | 164 ++++++++++++++++
 tb/tb_apb_slave_decoder_32bit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_dec_pkg.sv
// Shared definitions for the APB slave decoder: FSM encoding, error data, timeout width.
package apb_dec_pkg;

  localparam int unsigned TO_CNT_W      = 16;
  localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_SETUP   = 3'd1;
  localparam state_t ST_ACCESS  = 3'd2;
  localparam state_t ST_RESP    = 3'd3;
  localparam state_t ST_RELEASE = 3'd4;

endpackage

// File: rtl/apb_slave_decoder_32bit_timeout_cnt.sv
// ACCESS-phase watchdog counter for the APB decoder; exists only when APB_DEC_TIMEOUT_EN is defined.
`ifdef APB_DEC_TIMEOUT_EN
module apb_dec_timeout_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         term_c
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt_q <= '0;
    else if (clr)   cnt_q <= '0;
    else if (en)    cnt_q <= cnt_q + W'(1);
  end

  // Asserted during the limit-th enabled cycle since the last clear.
  assign term_c = en & (cnt_q == limit - W'(1));

endmodule
`endif

// File: rtl/apb_slave_decoder_32bit.sv
// Decodes master requests to NUM_SLV register slaves with a two-phase access and error response.
// Optional ACCESS watchdog enabled by defining APB_DEC_TIMEOUT_EN.
module apb_slave_decoder_32bit
  import apb_dec_pkg::*;
#(
  parameter int unsigned          AW        = 24,
  parameter int unsigned          DW        = 32,
  parameter int unsigned          NUM_SLV   = 4,
  parameter int unsigned          SEL_W     = 4,
  parameter logic [TO_CNT_W-1:0]  TIMEOUT   = 16'd1023,
  parameter logic [DW-1:0]        ERR_RDATA = DW'(ERR_RDATA_DEF)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p_ce,
  input  logic [AW-1:0]         p_addr,
  input  logic [DW-1:0]         p_wdata,
  input  logic                  p_enable,
  input  logic                  p_we,
  output logic                  p_rdy,
  output logic [DW-1:0]         p_rdata,
  output logic [NUM_SLV-1:0]    s_ce,
  output logic [NUM_SLV-1:0]    s_enable,
  output logic [AW-1:0]         s_addr,
  output logic [DW-1:0]         s_wdata,
  output logic                  s_we,
  input  logic [NUM_SLV-1:0]    s_rdy,
  input  logic [NUM_SLV*DW-1:0] s_rdata,
  output logic                  err_flag,
  input  logic                  err_clr
);

  state_t               state_q, state_n;
  logic [SEL_W-1:0]     idx_q, in_idx;
  logic [NUM_SLV-1:0]   sel_oh, in_oh;
  logic                 req, in_unmapped, rdy_hit, to_hit;
  logic [DW-1:0]        rd_sel;

  logic [NUM_SLV-1:0]   s_ce_d, s_en_d;
  logic                 p_rdy_d, err_set;
  logic [DW-1:0]        p_rdata_d;

  assign req         = p_ce & p_enable;
  assign in_idx      = p_addr[AW-1 -: SEL_W];
  assign in_unmapped = 32'(in_idx) >= NUM_SLV;
  assign in_oh       = NUM_SLV'(1) << in_idx;
  assign sel_oh      = NUM_SLV'(1) << idx_q;
  assign rdy_hit     = |(s_rdy & sel_oh);

  // Read-data mux for the selected slave.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (sel_oh[i]) rd_sel = rd_sel | s_rdata[i*DW +: DW];
    end
  end

`ifdef APB_DEC_TIMEOUT_EN
  apb_dec_timeout_cnt #(.W(TO_CNT_W)) u_to_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state_q == ST_SETUP),
    .en     (state_q == ST_ACCESS),
    .limit  (TIMEOUT),
    .term_c (to_hit)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign to_hit         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE:    if (req) state_n = in_unmapped ? ST_RESP : ST_SETUP;
      ST_SETUP:   state_n = ST_ACCESS;
      ST_ACCESS:  if (rdy_hit || to_hit) state_n = ST_RESP;
      ST_RESP:    state_n = ST_RELEASE;
      ST_RELEASE: if (!req) state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, keyed on the transition being taken.
  always_comb begin
    s_ce_d    = '0;
    s_en_d    = '0;
    p_rdy_d   = 1'b0;
    p_rdata_d = '0;
    err_set   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req && in_unmapped) begin
          p_rdy_d   = 1'b1;
          p_rdata_d = ERR_RDATA;
          err_set   = 1'b1;
        end else if (req) begin
          s_ce_d = in_oh;
        end
      end
      ST_SETUP: begin
        s_ce_d = sel_oh;
        s_en_d = sel_oh;
      end
      ST_ACCESS: begin
        if (rdy_hit) begin
          p_rdy_d   = 1'b1;
          p_rdata_d = s_we ? '0 : rd_sel;
        end else if (to_hit) begin
          p_rdy_d   = 1'b1;
          p_rdata_d = ERR_RDATA;
          err_set   = 1'b1;
        end else begin
          s_ce_d = sel_oh;
          s_en_d = sel_oh;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_rdy    <= 1'b0;
      p_rdata  <= '0;
      s_ce     <= '0;
      s_enable <= '0;
    end else begin
      p_rdy    <= p_rdy_d;
      p_rdata  <= p_rdata_d;
      s_ce     <= s_ce_d;
      s_enable <= s_en_d;
    end
  end

  // Request latch, shared by all slaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_addr  <= '0;
      s_wdata <= '0;
      s_we    <= 1'b0;
      idx_q   <= '0;
    end else if (state_q == ST_IDLE && req) begin
      s_addr  <= p_addr;
      s_wdata <= p_wdata;
      s_we    <= p_we;
      idx_q   <= in_idx;
    end
  end

  // Sticky error flag; a new error beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_flag <= 1'b0;
    else if (err_set) err_flag <= 1'b1;
    else if (err_clr) err_flag <= 1'b0;
  end

endmodule

// File: tb/tb_apb_slave_decoder_32bit.sv
// Directed self-checking bench for apb_slave_decoder_32bit (also covers APB_DEC_TIMEOUT_EN builds).
module tb_apb_slave_decoder_32bit;

  logic         clk = 1'b0;
  logic         rst_n, p_ce, p_enable, p_we, err_clr;
  logic [23:0]  p_addr;
  logic [31:0]  p_wdata;
  logic         p_rdy, s_we, err_flag;
  logic [31:0]  p_rdata, s_wdata;
  logic [3:0]   s_ce, s_enable, s_rdy;
  logic [23:0]  s_addr;
  logic [127:0] s_rdata;

  int n_asrt = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  apb_slave_decoder_32bit #(.TIMEOUT(16'd8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .p_ce     (p_ce),
    .p_addr   (p_addr),
    .p_wdata  (p_wdata),
    .p_enable (p_enable),
    .p_we     (p_we),
    .p_rdy    (p_rdy),
    .p_rdata  (p_rdata),
    .s_ce     (s_ce),
    .s_enable (s_enable),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_we     (s_we),
    .s_rdy    (s_rdy),
    .s_rdata  (s_rdata),
    .err_flag (err_flag),
    .err_clr  (err_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req_on(input logic [23:0] a, input logic [31:0] d, input logic we);
    p_addr = a; p_wdata = d; p_we = we; p_ce = 1'b1; p_enable = 1'b1;
  endtask

  task automatic req_off();
    p_ce = 1'b0; p_enable = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; p_ce = 1'b0; p_enable = 1'b0; p_we = 1'b0; err_clr = 1'b0;
    p_addr = '0; p_wdata = '0; s_rdy = '0; s_rdata = '0;
    #12;
    chk("rst_p_rdy", p_rdy, 1'b0);
    chk("rst_p_rdata", p_rdata, 32'h0);
    chk("rst_s_ce", s_ce, 4'h0);
    chk("rst_s_enable", s_enable, 4'h0);
    chk("rst_s_addr", s_addr, 24'h0);
    chk("rst_s_wdata", s_wdata, 32'h0);
    chk("rst_s_we", s_we, 1'b0);
    chk("rst_err_flag", err_flag, 1'b0);
    rst_n = 1'b1;
    tick();

    // Write to slave 1, ready on first ACCESS cycle: minimum latency.
    req_on(24'h1000_40, 32'h1234_5678, 1'b1);
    tick();
    chk("wr_c1_s_ce", s_ce, 4'b0010);
    chk("wr_c1_s_enable", s_enable, 4'b0000);
    chk("wr_s_addr", s_addr, 24'h1000_40);
    chk("wr_s_wdata", s_wdata, 32'h1234_5678);
    chk("wr_s_we", s_we, 1'b1);
    tick();
    chk("wr_c2_s_ce", s_ce, 4'b0010);
    chk("wr_c2_s_enable", s_enable, 4'b0010);
    chk("wr_c2_p_rdy", p_rdy, 1'b0);
    s_rdy = 4'b0010;
    tick();
    chk("wr_c3_p_rdy", p_rdy, 1'b1);
    chk("wr_c3_p_rdata", p_rdata, 32'h0);
    chk("wr_c3_s_ce", s_ce, 4'b0000);
    chk("wr_c3_s_enable", s_enable, 4'b0000);
    chk("wr_err_flag", err_flag, 1'b0);
    req_off(); s_rdy = '0;
    tick();
    chk("wr_c4_p_rdy", p_rdy, 1'b0);
    tick();

    // Read slave 3 with 5 wait cycles; master drops strobe in SETUP; slave 1 ready ignored.
    s_rdata[127:96] = 32'hCAFE_0001;
    s_rdata[63:32]  = 32'h1111_1111;
    req_on(24'h3000_00, 32'h0, 1'b0);
    tick();
    chk("rd_c1_s_ce", s_ce, 4'b1000);
    req_off();
    s_rdy = 4'b0010;
    tick();
    chk("rd_c2_s_enable", s_enable, 4'b1000);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rd_wait_p_rdy", p_rdy, 1'b0);
      chk("rd_wait_s_enable", s_enable, 4'b1000);
    end
    s_rdy = 4'b1010;
    tick();
    chk("rd_p_rdy", p_rdy, 1'b1);
    chk("rd_p_rdata", p_rdata, 32'hCAFE_0001);
    s_rdy = '0;
    tick();
    chk("rd_single_pulse", p_rdy, 1'b0);
    tick();

    // Unmapped index 7: immediate error response, sticky flag, clear.
    req_on(24'h7000_00, 32'h0, 1'b0);
    tick();
    chk("um_p_rdy", p_rdy, 1'b1);
    chk("um_p_rdata", p_rdata, 32'hDEAD_BEEF);
    chk("um_s_ce", s_ce, 4'b0000);
    chk("um_err_flag", err_flag, 1'b1);
    req_off();
    tick();
    chk("um_p_rdy_drop", p_rdy, 1'b0);
    chk("um_err_sticky", err_flag, 1'b1);
    err_clr = 1'b1;
    tick();
    chk("um_err_cleared", err_flag, 1'b0);

    // Unmapped write with simultaneous clear: set wins.
    req_on(24'h7000_00, 32'h5555_5555, 1'b1);
    tick();
    chk("umw_p_rdata", p_rdata, 32'hDEAD_BEEF);
    chk("umw_set_wins", err_flag, 1'b1);
    req_off();
    tick();
    chk("umw_err_cleared", err_flag, 1'b0);
    err_clr = 1'b0;
    tick();

    // Slave 0 never ready.
    s_rdata[31:0] = 32'h0000_5A5A;
    req_on(24'h0000_00, 32'h0, 1'b0);
    tick();
    req_off();
    tick();
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("to_wait_p_rdy", p_rdy, 1'b0);
      chk("to_wait_s_enable", s_enable, 4'b0001);
    end
`ifdef APB_DEC_TIMEOUT_EN
    tick();
    chk("to_p_rdy", p_rdy, 1'b1);
    chk("to_p_rdata", p_rdata, 32'hDEAD_BEEF);
    chk("to_err_flag", err_flag, 1'b1);
    tick();
    tick();
    req_on(24'h0000_00, 32'h0, 1'b0);
    tick();
    req_off();
    tick();
    for (int i = 0; i < 7; i++) tick();
    s_rdy = 4'b0001;
    tick();
    chk("to_edge_p_rdy", p_rdy, 1'b1);
    chk("to_edge_p_rdata", p_rdata, 32'h0000_5A5A);
    chk("to_edge_err_flag", err_flag, 1'b1);
`else
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("nto_p_rdy", p_rdy, 1'b0);
      chk("nto_s_enable", s_enable, 4'b0001);
    end
    s_rdy = 4'b0001;
    tick();
    chk("nto_p_rdy_late", p_rdy, 1'b1);
    chk("nto_p_rdata", p_rdata, 32'h0000_5A5A);
    chk("nto_err_flag", err_flag, 1'b0);
`endif
    s_rdy = '0;
    tick();
    tick();

    // Held strobe after p_rdy must not retrigger.
    s_rdy = 4'b0100;
    req_on(24'h2000_00, 32'h0000_ABCD, 1'b1);
    tick();
    tick();
    tick();
    chk("hold_p_rdy", p_rdy, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_no_p_rdy", p_rdy, 1'b0);
      chk("hold_no_s_ce", s_ce, 4'b0000);
    end
    req_off();
    tick();
    chk("hold_release", p_rdy, 1'b0);
    s_rdy = '0;
    tick();

    // Asynchronous reset mid-ACCESS, then a fresh read.
    s_rdata[63:32] = 32'hA5A5_0011;
    req_on(24'h1000_00, 32'h0, 1'b0);
    tick();
    tick();
    chk("ar_pre_s_enable", s_enable, 4'b0010);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_s_ce", s_ce, 4'b0000);
    chk("ar_s_enable", s_enable, 4'b0000);
    chk("ar_p_rdy", p_rdy, 1'b0);
    req_off();
    #1 rst_n = 1'b1;
    tick();
    s_rdy = 4'b0010;
    req_on(24'h1000_00, 32'h0, 1'b0);
    tick();
    chk("ar2_s_ce", s_ce, 4'b0010);
    tick();
    tick();
    chk("ar2_p_rdy", p_rdy, 1'b1);
    chk("ar2_p_rdata", p_rdata, 32'hA5A5_0011);
    req_off(); s_rdy = '0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
